// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, column reset
// pattern, default timing parameters and small row/column helpers.
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } kp_state_e;

   localparam logic [3:0] COLS_RESET          = 4'b1110;
   localparam int         SCAN_DIV_DEF        = 50000;
   localparam int         DEBOUNCE_TICKS_DEF  = 20;

   // True when exactly one line of an active-low nibble is asserted.
   function automatic logic single_low(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   // Index of the lowest asserted (low) line; 0 when none is low.
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Advance the column drive: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
   function automatic logic [3:0] rotl(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 and flags the last count as Tick.
module scan_prescaler #(
   parameter int DIV = 50000
) (
   input  logic Clk,
   input  logic nReset,
   output logic Tick
);

   localparam int            CW   = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo-DIV count; wraps back to zero after the tick cycle.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset)          cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
   end

   assign Tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column driven at a time,
// synchronised active-low rows, press/release debounce, one KeyValid pulse
// per accepted key and a four-code KeyData history (newest in [3:0]).
//
// state    | meaning
// SCAN     | rotate the driven column each tick, look for a single low row
// DEBOUNCE | column frozen, counting consecutive matching tick samples
// HELD     | key accepted, column frozen until all rows stay high long enough
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV       = SCAN_DIV_DEF,
   parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
   input  logic        Clk,
   input  logic        nReset,
   input  logic [3:0]  Rows,
   input  logic        ClearData,
   output logic [3:0]  Cols,
   output logic [3:0]  KeyCode,
   output logic        KeyValid,
   output logic        KeyHeld,
   output logic [15:0] KeyData
);

   localparam int            DW    = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DW-1:0] DEB_N = DW'(DEBOUNCE_TICKS);

   logic          tick;
   logic [3:0]    rows_m, rows_s;
   kp_state_e     state, state_n;
   logic [3:0]    cols_q, cols_n;
   logic [1:0]    row_idx, row_idx_n, col_idx, col_idx_n;
   logic [DW-1:0] deb_cnt, deb_cnt_n, rel_cnt, rel_cnt_n;
   logic [DW-1:0] deb_inc, rel_inc;
   logic [3:0]    match_pat;
   logic [3:0]    key_code, key_code_n;
   logic          key_valid, key_valid_n;
   logic          key_held, key_held_n;
   logic [15:0]   key_data, key_data_n;

   scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
      .Clk    (Clk),
      .nReset (nReset),
      .Tick   (tick)
   );

   // Two-flop synchroniser; idle rows are pulled high, so reset to all ones.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         rows_m <= 4'hF;
         rows_s <= 4'hF;
      end else begin
         rows_m <= Rows;
         rows_s <= rows_m;
      end
   end

   // Saturating counter increments and the row pattern expected while debouncing.
   assign deb_inc   = (deb_cnt == DEB_N) ? deb_cnt : deb_cnt + DW'(1);
   assign rel_inc   = (rel_cnt == DEB_N) ? rel_cnt : rel_cnt + DW'(1);
   assign match_pat = ~(4'b0001 << row_idx);

   // State, column drive, debounce counters and key outputs.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state     <= SCAN;
         cols_q    <= COLS_RESET;
         row_idx   <= 2'd0;
         col_idx   <= 2'd0;
         deb_cnt   <= '0;
         rel_cnt   <= '0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         key_data  <= 16'd0;
      end else begin
         state     <= state_n;
         cols_q    <= cols_n;
         row_idx   <= row_idx_n;
         col_idx   <= col_idx_n;
         deb_cnt   <= deb_cnt_n;
         rel_cnt   <= rel_cnt_n;
         key_code  <= key_code_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
         key_data  <= key_data_n;
      end
   end

   // Next-state logic; all row decisions are made on tick cycles only.
   always_comb begin
      state_n     = state;
      cols_n      = cols_q;
      row_idx_n   = row_idx;
      col_idx_n   = col_idx;
      deb_cnt_n   = deb_cnt;
      rel_cnt_n   = rel_cnt;
      key_code_n  = key_code;
      key_valid_n = 1'b0;
      key_held_n  = key_held;
      case (state)
         SCAN: begin
            if (tick) begin
               if (single_low(rows_s)) begin
                  row_idx_n = low_idx(rows_s);
                  col_idx_n = low_idx(cols_q);
                  deb_cnt_n = '0;
                  state_n   = DEBOUNCE;
               end else begin
                  cols_n = rotl(cols_q);
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (rows_s == match_pat) begin
                  if (deb_inc >= DEB_N) begin
                     key_valid_n = 1'b1;
                     key_code_n  = {row_idx, col_idx};
                     key_held_n  = 1'b1;
                     deb_cnt_n   = '0;
                     rel_cnt_n   = '0;
                     state_n     = HELD;
                  end else begin
                     deb_cnt_n = deb_inc;
                  end
               end else begin
                  deb_cnt_n = '0;
                  cols_n    = rotl(cols_q);
                  state_n   = SCAN;
               end
            end
         end
         HELD: begin
            if (tick) begin
               if (rows_s == 4'hF) begin
                  if (rel_inc >= DEB_N) begin
                     key_held_n = 1'b0;
                     rel_cnt_n  = '0;
                     cols_n     = rotl(cols_q);
                     state_n    = SCAN;
                  end else begin
                     rel_cnt_n = rel_inc;
                  end
               end else begin
                  rel_cnt_n = '0;
               end
            end
         end
         default: begin
            state_n = SCAN;
         end
      endcase
   end

   // History shift happens in the KeyValid cycle; a clear in that cycle wins.
   always_comb begin
      key_data_n = key_data;
      if (ClearData)      key_data_n = 16'd0;
      else if (key_valid) key_data_n = {key_data[11:0], key_code};
   end

   assign Cols     = cols_q;
   assign KeyCode  = key_code;
   assign KeyValid = key_valid;
   assign KeyHeld  = key_held;
   assign KeyData  = key_data;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3. A keypad model
// pulls a row low while a pressed key's column is driven low. Stimulus pushes
// expected key events into a queue; a monitor pops and checks each KeyValid.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_data = 1'b0;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] key_data;
   logic [3:0]  keys [4];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] data;
      int          tick;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_data = 16'd0;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
      .Clk       (clk),
      .nReset    (rst_n),
      .Rows      (rows),
      .ClearData (clear_data),
      .Cols      (cols),
      .KeyCode   (key_code),
      .KeyValid  (key_valid),
      .KeyHeld   (key_held),
      .KeyData   (key_data)
   );

   always #5 clk = ~clk;

   // Keypad matrix model.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r][c] && !cols[c]) rows[r] = 1'b0;
   end

   // Bench-side tick reference: ticks fall on every SD-th edge after reset.
   int pc = 0;
   int tick_no = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= 0;
      else if (pc == SD - 1) begin
         pc      <= 0;
         tick_no <= tick_no + 1;
      end else pc <= pc + 1;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (tick %0d)", name, act, exp, tick_no);
      end
   endtask

   function automatic logic [3:0] rotl_n(logic [3:0] v, int n);
      for (int i = 0; i < n; i++) v = {v[2:0], v[3]};
      return v;
   endfunction

   task automatic wait_tick(int t);
      int guard = 0;
      while (tick_no < t && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) check("tick_timeout", 32'(tick_no), 32'(t));
   endtask

   // Press a key right after its column becomes driven; tp is that tick.
   task automatic press(int r, int c, output int tp);
      int guard = 0;
      @(negedge clk);
      while (!(pc == 0 && cols[c] == 1'b0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("press_col_timeout", 32'(cols), 32'(c));
      keys[r][c] = 1'b1;
      tp = tick_no;
   endtask

   task automatic expect_key(int r, int c, int t, bit clr);
      logic [3:0] code;
      code = {r[1:0], c[1:0]};
      exp_data = clr ? 16'd0 : {exp_data[11:0], code};
      sb.push_back('{code: code, data: exp_data, tick: t});
   endtask

   // Detection one tick after press, three confirming ticks, pulse after the last.
   task automatic tap(int r, int c, bit clr);
      int tp;
      press(r, c, tp);
      expect_key(r, c, tp + 4, clr);
      wait_tick(tp + 4);
      if (clr) begin
         clear_data = 1'b1;
         @(negedge clk);
         clear_data = 1'b0;
      end
      wait_tick(tp + 5);
      keys[r][c] = 1'b0;
      wait_tick(tp + 7);
      check("held_until_release_debounced", 32'(key_held), 32'd1);
      wait_tick(tp + 8);
      check("held_cleared", 32'(key_held), 32'd0);
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t        e;
      bit          chk_data = 1'b0;
      logic [15:0] pend_data = 16'd0;
      forever begin
         @(negedge clk);
         if (chk_data) begin
            check("keydata_after_valid", 32'(key_data), 32'(pend_data));
            chk_data = 1'b0;
         end
         if (rst_n && key_valid) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_keyvalid: got code %0h at tick %0d, expected no pulse", key_code, tick_no);
            end else begin
               e = sb.pop_front();
               check("keycode", 32'(key_code), 32'(e.code));
               check("keyheld_at_valid", 32'(key_held), 32'd1);
               check("valid_tick", 32'(tick_no), 32'(e.tick));
               pend_data = e.data;
               chk_data  = 1'b1;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tp, r0, t3;
      for (int r = 0; r < 4; r++) keys[r] = 4'h0;
      repeat (3) @(negedge clk);

      // 1: reset values, then free scanning
      check("rst_cols", 32'(cols), 32'h0000000E);
      check("rst_code", 32'(key_code), 32'd0);
      check("rst_valid", 32'(key_valid), 32'd0);
      check("rst_held", 32'(key_held), 32'd0);
      check("rst_data", 32'(key_data), 32'd0);
      rst_n = 1'b1;
      r0 = tick_no;
      repeat (16) begin
         @(negedge clk);
         check("scan_cols", 32'(cols), 32'(rotl_n(4'b1110, (tick_no - r0) % 4)));
      end

      // 2: row2/col1 held for 10 ticks -> code 9, single pulse
      press(2, 1, tp);
      expect_key(2, 1, tp + 4, 1'b0);
      wait_tick(tp + 1);
      check("frozen_in_debounce", 32'(cols), 32'h0000000D);
      wait_tick(tp + 4);
      check("held_set", 32'(key_held), 32'd1);
      wait_tick(tp + 10);
      check("frozen_in_held", 32'(cols), 32'h0000000D);
      keys[2][1] = 1'b0;
      wait_tick(tp + 12);
      check("held_two_release_ticks", 32'(key_held), 32'd1);
      wait_tick(tp + 13);
      check("held_dropped", 32'(key_held), 32'd0);
      check("rotate_after_release", 32'(cols), 32'h0000000B);
      wait_tick(tp + 14);
      check("scan_resumed", 32'(cols), 32'h00000007);

      // 3: one-tick bounce at row1/col3
      press(1, 3, tp);
      wait_tick(tp + 1);
      check("bounce_frozen", 32'(cols), 32'h00000007);
      keys[1][3] = 1'b0;
      wait_tick(tp + 2);
      check("bounce_back_to_scan", 32'(cols), 32'h0000000E);
      wait_tick(tp + 3);
      check("bounce_rotating", 32'(cols), 32'h0000000D);
      check("bounce_not_held", 32'(key_held), 32'd0);
      t3 = tp + 3;

      // 4: rows 0 and 3 both low on column 2 are ignored
      keys[0][2] = 1'b1;
      keys[3][2] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         wait_tick(t3 + k);
         check("multi_row_rotate", 32'(cols), 32'(rotl_n(4'b1101, k)));
      end
      keys[0][2] = 1'b0;
      keys[3][2] = 1'b0;
      tap(0, 1, 1'b0);
      tap(0, 2, 1'b0);
      tap(0, 3, 1'b0);
      tap(1, 0, 1'b0);
      check("keydata_1234", 32'(key_data), 32'h00001234);

      // 5: ClearData in the KeyValid cycle, then one more key
      tap(2, 2, 1'b1);
      check("keydata_cleared", 32'(key_data), 32'd0);
      tap(3, 3, 1'b0);
      check("keydata_000f", 32'(key_data), 32'h0000000F);

      // 6: reset mid-debounce, key kept down through reset release
      press(1, 2, tp);
      wait_tick(tp + 2);
      rst_n = 1'b0;
      #1;
      check("midrst_cols", 32'(cols), 32'h0000000E);
      check("midrst_code", 32'(key_code), 32'd0);
      check("midrst_valid", 32'(key_valid), 32'd0);
      check("midrst_held", 32'(key_held), 32'd0);
      check("midrst_data", 32'(key_data), 32'd0);
      repeat (3) @(negedge clk);
      exp_data = 16'd0;
      rst_n = 1'b1;
      r0 = tick_no;
      // col0 at release, col2 driven after two ticks, detect, three confirms
      expect_key(1, 2, r0 + 6, 1'b0);
      wait_tick(r0 + 7);
      keys[1][2] = 1'b0;
      wait_tick(r0 + 11);
      check("post_reset_held_cleared", 32'(key_held), 32'd0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
